// File: rtl/exec_unit.sv
// Decode/execute stage of the 4-bit processor: FETCH/EXEC/JADDR/HALT sequencer, 4-bit ALU with
// carry/zero flags and an output port. Optional macro COND_JUMP_EN enables taken JC/JZ jumps.
module exec_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  instruccion,
  input  logic [3:0]  operando,
  input  logic [7:0]  Program_byte,
  input  logic [3:0]  data_in,
  output logic        enabled_fetch,
  output logic        enabledCounter,
  output logic        loadCounter,
  output logic [11:0] pc_target,
  output logic [3:0]  acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  data_out,
  output logic        out_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StJaddr = 2'b10,
    StHalt  = 2'b11
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLit  = 4'h1;
  localparam logic [3:0] OpIn   = 4'h2;
  localparam logic [3:0] OpOut  = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpCmp  = 4'h9;
  localparam logic [3:0] OpNot  = 4'hA;
  localparam logic [3:0] OpJmp  = 4'hB;
  localparam logic [3:0] OpJc   = 4'hC;
  localparam logic [3:0] OpJz   = 4'hD;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e      state_q, state_d;
  logic [3:0]  acc_q, acc_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic [3:0]  dout_q, dout_d;
  logic        ov_q, ov_d;
  logic [3:0]  jmp_op_q, jmp_op_d;
  logic [11:0] pc_q, pc_d;

  logic [4:0]  sum;
  logic [4:0]  diff;
  logic        jump_taken;

  // Zero-extended 5-bit arithmetic: sum[4] is carry, diff[4] is borrow (acc < operando).
  assign sum  = {1'b0, acc_q} + {1'b0, operando};
  assign diff = {1'b0, acc_q} - {1'b0, operando};

  // Flags are untouched in EXEC/JADDR of a jump, so the live flags are the entry values.
  always_comb begin
    jump_taken = 1'b0;
    case (jmp_op_q)
      OpJmp:   jump_taken = 1'b1;
`ifdef COND_JUMP_EN
      OpJc:    jump_taken = c_q;
      OpJz:    jump_taken = z_q;
`else
      OpJc:    jump_taken = 1'b0;
      OpJz:    jump_taken = 1'b0;
`endif
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    c_d      = c_q;
    z_d      = z_q;
    dout_d   = dout_q;
    ov_d     = ov_q;
    jmp_op_d = jmp_op_q;
    pc_d     = pc_q;
    if (run) begin
      ov_d = 1'b0;
      unique case (state_q)
        StFetch: state_d = StExec;
        StExec: begin
          state_d = StFetch;
          case (instruccion)
            OpNop: ;
            OpLit: acc_d = operando;
            OpIn:  acc_d = data_in;
            OpOut: begin
              dout_d = acc_q;
              ov_d   = 1'b1;
            end
            OpAdd: begin
              acc_d = sum[3:0];
              c_d   = sum[4];
              z_d   = (sum[3:0] == 4'h0);
            end
            OpSub: begin
              acc_d = diff[3:0];
              c_d   = diff[4];
              z_d   = (diff[3:0] == 4'h0);
            end
            OpAnd: begin
              acc_d = acc_q & operando;
              z_d   = ((acc_q & operando) == 4'h0);
            end
            OpOr: begin
              acc_d = acc_q | operando;
              z_d   = ((acc_q | operando) == 4'h0);
            end
            OpXor: begin
              acc_d = acc_q ^ operando;
              z_d   = ((acc_q ^ operando) == 4'h0);
            end
            OpCmp: begin
              c_d = diff[4];
              z_d = (diff[3:0] == 4'h0);
            end
            OpNot: begin
              acc_d = ~acc_q;
              z_d   = (~acc_q == 4'h0);
            end
            OpJmp, OpJc, OpJz: begin
              jmp_op_d = instruccion;
              state_d  = StJaddr;
            end
            OpHalt:  state_d = StHalt;
            default: ;
          endcase
        end
        StJaddr: begin
          state_d = StFetch;
          if (jump_taken) begin
            pc_d = {operando, Program_byte};
          end
        end
        StHalt: state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      acc_q    <= 4'h0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      dout_q   <= 4'h0;
      ov_q     <= 1'b0;
      jmp_op_q <= OpNop;
      pc_q     <= RESET_PC;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      dout_q   <= dout_d;
      ov_q     <= ov_d;
      jmp_op_q <= jmp_op_d;
      pc_q     <= pc_d;
    end
  end

  // Strobes are gated by reset too so they drop the moment reset asserts.
  always_comb begin
    enabled_fetch  = run && reset && (state_q == StFetch);
    enabledCounter = run && reset &&
                     ((state_q == StFetch) || ((state_q == StJaddr) && !jump_taken));
    loadCounter    = run && reset && (state_q == StJaddr) && jump_taken;
    pc_target      = ((state_q == StJaddr) && jump_taken) ? {operando, Program_byte} : pc_q;
    acc            = acc_q;
    flag_c         = c_q;
    flag_z         = z_q;
    data_out       = dout_q;
    out_valid      = ov_q && run;
    halted         = (state_q == StHalt);
  end

endmodule
